// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_2p_bwe storage primitive.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Same-address read-during-write behaviour.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

    // Selects the new byte where its enable is set, otherwise keeps the old one.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_2p_array.sv
// Storage array: one lane-masked write port, one registered read port (old data on collision).
// Latency: read data appears on the edge that samples re_i; writes are visible one edge later.
// Backpressure: none; the caller keeps both addresses in range whenever the enables are high.
module ram_2p_array #(
    parameter int DEPTH = 16,
    parameter int NB    = 4,
    parameter int LW    = 8,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [NB-1:0]    be_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [NB*LW-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [NB*LW-1:0] rdata_o
);

    logic [NB*LW-1:0] mem_q [DEPTH];
    logic [NB*LW-1:0] rdata_q;

    // Lane-masked write; the array itself carries no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i*LW +: LW] <= wdata_i[i*LW +: LW];
                end
            end
        end
    end

    // Registered read; holds its value when no read is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_2p_bwe.sv
// Dual-port RAM with byte write enables, read-during-write select, optional output register,
// clear sweep after reset/CLR, and per-byte parity when MEM_PARITY_EN is defined.
// Latency: read data 0 cycles after the sampling edge (1 with OUT_REG); READY low during the sweep.
module ram_2p_bwe #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 16,
    parameter int               RDW_MODE = 0,
    parameter int               OUT_REG  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int              NB       = WIDTH / 8,
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CS,
    input  logic             WE,
    input  logic [NB-1:0]    WBE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE,
    input  logic [AW-1:0]    RADDR,
    input  logic             CLR,
`ifdef MEM_PARITY_EN
    input  logic             PINJ,
    output logic             PERR,
`endif
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    output logic             READY
);

    import ram_pkg::*;

    // Each lane is a data byte, plus its parity bit when parity is enabled.
`ifdef MEM_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif
    localparam int              ADW     = NB * LW;
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_A  = AW'(DEPTH - 1);

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             ready_q;

    logic             w_inr, r_inr;
    logic             usr_wr, usr_rd, byp;
    logic [ADW-1:0]   usr_word, init_word;

    logic             arr_we, arr_re;
    logic [NB-1:0]    arr_be;
    logic [AW-1:0]    arr_wa;
    logic [ADW-1:0]   arr_wd, arr_rd;

    logic             rvld_q, oob_q, byp_q;
    logic [NB-1:0]    bbe_q;
    logic [ADW-1:0]   bwd_q;
    logic [WIDTH-1:0] rd_dat;
`ifdef MEM_PARITY_EN
    logic             rd_err;
`endif

    // Sweep/run FSM: INIT walks cnt over every address, RUN accepts user traffic.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (cnt_q == LAST_A) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                RUN: begin
                    if (CLR) begin
                        state_q <= INIT;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign READY  = ready_q;
    assign w_inr  = ({1'b0, WADDR} < DEPTH_C);
    assign r_inr  = ({1'b0, RADDR} < DEPTH_C);
    assign usr_wr = ready_q & CS & WE & w_inr;
    assign usr_rd = ready_q & CS & RE;
    assign byp    = usr_wr & usr_rd & r_inr & (WADDR == RADDR) & (RDW_MODE == RDW_NEW);

    // Pack user and sweep data into lanes; PINJ flips the stored byte-0 parity.
    always_comb begin
        usr_word  = '0;
        init_word = '0;
        for (int i = 0; i < NB; i++) begin
            usr_word[i*LW +: 8]  = WDATA[i*8 +: 8];
            init_word[i*LW +: 8] = INIT_VAL[i*8 +: 8];
`ifdef MEM_PARITY_EN
            usr_word[i*LW + 8]  = byte_par(WDATA[i*8 +: 8]);
            init_word[i*LW + 8] = byte_par(INIT_VAL[i*8 +: 8]);
`endif
        end
`ifdef MEM_PARITY_EN
        usr_word[8] = byte_par(WDATA[7:0]) ^ PINJ;
`endif
    end

    // The sweep owns the write port in INIT; user writes are ignored there.
    always_comb begin
        if (state_q == INIT) begin
            arr_we = 1'b1;
            arr_be = '1;
            arr_wa = cnt_q;
            arr_wd = init_word;
        end else begin
            arr_we = usr_wr;
            arr_be = WBE;
            arr_wa = WADDR;
            arr_wd = usr_word;
        end
    end

    assign arr_re = usr_rd & r_inr;

    ram_2p_array #(
        .DEPTH (DEPTH),
        .NB    (NB),
        .LW    (LW),
        .AW    (AW)
    ) u_array (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .waddr_i (arr_wa),
        .wdata_i (arr_wd),
        .re_i    (arr_re),
        .raddr_i (RADDR),
        .rdata_o (arr_rd)
    );

    // Capture read side-band (valid, out-of-range, bypass lanes) alongside the array read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rvld_q <= 1'b0;
            oob_q  <= 1'b0;
            byp_q  <= 1'b0;
            bbe_q  <= '0;
            bwd_q  <= '0;
        end else begin
            rvld_q <= usr_rd;
            if (usr_rd) begin
                oob_q <= ~r_inr;
                byp_q <= byp;
                bbe_q <= WBE;
                bwd_q <= usr_word;
            end
        end
    end

    // Merge bypassed lanes over the old word, then check parity on the merged result.
    always_comb begin
        rd_dat = '0;
`ifdef MEM_PARITY_EN
        rd_err = 1'b0;
`endif
        for (int i = 0; i < NB; i++) begin
            rd_dat[i*8 +: 8] = byte_merge(arr_rd[i*LW +: 8], bwd_q[i*LW +: 8], byp_q & bbe_q[i]);
`ifdef MEM_PARITY_EN
            rd_err = rd_err | (byte_par(rd_dat[i*8 +: 8]) ^
                               ((byp_q & bbe_q[i]) ? bwd_q[i*LW + 8] : arr_rd[i*LW + 8]));
`endif
        end
        if (oob_q) begin
            rd_dat = INIT_VAL;
`ifdef MEM_PARITY_EN
            rd_err = 1'b0;
`endif
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] odat_q;
            logic             ovld_q;
`ifdef MEM_PARITY_EN
            logic             oerr_q;
`endif
            // Extra pipeline stage; data and error only move with a valid result.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    odat_q <= '0;
                    ovld_q <= 1'b0;
`ifdef MEM_PARITY_EN
                    oerr_q <= 1'b0;
`endif
                end else begin
                    ovld_q <= rvld_q;
                    if (rvld_q) begin
                        odat_q <= rd_dat;
`ifdef MEM_PARITY_EN
                        oerr_q <= rd_err;
`endif
                    end
                end
            end
            assign RDATA  = odat_q;
            assign RVALID = ovld_q;
`ifdef MEM_PARITY_EN
            assign PERR   = ovld_q & oerr_q;
`endif
        end else begin : g_direct
            assign RDATA  = rd_dat;
            assign RVALID = rvld_q;
`ifdef MEM_PARITY_EN
            assign PERR   = rvld_q & rd_err;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ram_2p_bwe.sv
// Directed bench: dut0 (old-data, no output reg), dut1 (new-data, output reg),
// dut2 (DEPTH=10, exercises out-of-range reads). All share the same stimulus.
module tb_ram_2p_bwe;

    localparam logic [31:0] IV  = 32'hA5A5A5A5;
    localparam logic [31:0] IV2 = 32'h5A5A0F0F;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET, CS, WE, RE, CLR;
    logic [3:0]  WBE, WADDR, RADDR;
    logic [31:0] WDATA;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        rvalid0, rvalid1, rvalid2;
    logic        ready0, ready1, ready2;
`ifdef MEM_PARITY_EN
    logic        PINJ;
    logic        perr0, perr1, perr2;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    logic        cs_v;
    logic        p_vld;
    logic [31:0] p_dat;

    ram_2p_bwe #(.WIDTH(32), .DEPTH(16), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(IV)) dut0 (
        .CLK(clk), .RESET(RESET), .CS(CS), .WE(WE), .WBE(WBE), .WADDR(WADDR), .WDATA(WDATA),
        .RE(RE), .RADDR(RADDR), .CLR(CLR),
`ifdef MEM_PARITY_EN
        .PINJ(PINJ), .PERR(perr0),
`endif
        .RDATA(rdata0), .RVALID(rvalid0), .READY(ready0));

    ram_2p_bwe #(.WIDTH(32), .DEPTH(16), .RDW_MODE(1), .OUT_REG(1), .INIT_VAL(IV)) dut1 (
        .CLK(clk), .RESET(RESET), .CS(CS), .WE(WE), .WBE(WBE), .WADDR(WADDR), .WDATA(WDATA),
        .RE(RE), .RADDR(RADDR), .CLR(CLR),
`ifdef MEM_PARITY_EN
        .PINJ(PINJ), .PERR(perr1),
`endif
        .RDATA(rdata1), .RVALID(rvalid1), .READY(ready1));

    ram_2p_bwe #(.WIDTH(32), .DEPTH(10), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(IV2)) dut2 (
        .CLK(clk), .RESET(RESET), .CS(CS), .WE(WE), .WBE(WBE), .WADDR(WADDR), .WDATA(WDATA),
        .RE(RE), .RADDR(RADDR), .CLR(CLR),
`ifdef MEM_PARITY_EN
        .PINJ(PINJ), .PERR(perr2),
`endif
        .RDATA(rdata2), .RVALID(rvalid2), .READY(ready2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access cycle. dut0 result is checked now; dut1's (one cycle later) is queued.
    task automatic cyc(input logic we, input logic [3:0] wbe, input logic [3:0] wa,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra,
                       input logic ev, input logic [31:0] e0, input logic [31:0] e1);
        CS = cs_v; WE = we; WBE = wbe; WADDR = wa; WDATA = wd; RE = re; RADDR = ra;
        tick();
        check("rvalid0", {31'd0, rvalid0}, {31'd0, ev});
        if (ev) check("rdata0", rdata0, e0);
        check("rvalid1", {31'd0, rvalid1}, {31'd0, p_vld});
        if (p_vld) check("rdata1", rdata1, p_dat);
        p_vld = ev;
        p_dat = e1;
        WE = 1'b0;
        RE = 1'b0;
    endtask

    // Count edges until each READY rises; a missing rise leaves its count at 0.
    task automatic wait_ready(output int n0, output int n1, output int n2);
        n0 = 0; n1 = 0; n2 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready0 && n0 == 0) n0 = i;
            if (ready1 && n1 == 0) n1 = i;
            if (ready2 && n2 == 0) n2 = i;
            if (n0 != 0 && n1 != 0 && n2 != 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, n1, n2, n, nv;
        RESET = 1'b1; CS = 1'b0; WE = 1'b0; RE = 1'b0; CLR = 1'b0;
        WBE = '0; WADDR = '0; RADDR = '0; WDATA = '0;
        cs_v = 1'b1; p_vld = 1'b0; p_dat = '0;
`ifdef MEM_PARITY_EN
        PINJ = 1'b0;
`endif
        tick();
        tick();
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        check("rst_ready1", {31'd0, ready1}, 32'd0);

        // Sweep after reset release
        RESET = 1'b0;
        wait_ready(n0, n1, n2);
        check("sweep_len0", n0, 16);
        check("sweep_len1", n1, 16);
        check("sweep_len2", n2, 10);

        // Every word holds INIT_VAL, back-to-back reads
        for (int a = 0; a < 16; a++) cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b1, IV, IV);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);

        // Byte enables, WBE=0 no-op, CS gating
        cyc(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 4'b0101, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b1, 32'h11BB33DD, 32'h11BB33DD);
        cyc(1'b1, 4'h0, 4'd3, 32'hFFFFFFFF, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cs_v = 1'b0;
        cyc(1'b1, 4'hF, 4'd3, 32'h00000000, 1'b1, 4'd3, 1'b0, 32'h0, 32'h0);
        cs_v = 1'b1;
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b1, 32'h11BB33DD, 32'h11BB33DD);

        // Read-during-write at address 5 (dut0 old data, dut1 merged new data)
        cyc(1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 4'b0011, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5, 1'b1, 32'h0, 32'h0000BEEF);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5, 1'b1, 32'h0000BEEF, 32'h0000BEEF);
        // Different addresses are independent
        cyc(1'b1, 4'hF, 4'd6, 32'h12345678, 1'b1, 4'd5, 1'b1, 32'h0000BEEF, 32'h0000BEEF);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd6, 1'b1, 32'h12345678, 32'h12345678);

        // Latency and throughput: reads of 1, 2, 3 back to back, then hold
        cyc(1'b1, 4'hF, 4'd1, 32'h01010101, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 4'hF, 4'd2, 32'h02020202, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd1, 1'b1, 32'h01010101, 32'h01010101);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2, 1'b1, 32'h02020202, 32'h02020202);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b1, 32'h11BB33DD, 32'h11BB33DD);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        check("hold_rdata0", rdata0, 32'h11BB33DD);
        check("hold_rdata1", rdata1, 32'h11BB33DD);

        // CLR while reading address 2
        cyc(1'b1, 4'hF, 4'd2, 32'h00000077, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        CLR = 1'b1;
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2, 1'b1, 32'h00000077, 32'h00000077);
        CLR = 1'b0;
        check("clr_ready_fall", {31'd0, ready0}, 32'd0);
        CS = 1'b1; WE = 1'b1; WBE = 4'hF; WADDR = 4'd0; WDATA = 32'hBAD0BAD0;
        RE = 1'b1; RADDR = 4'd2;
        tick();
        check("clr_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("clr_pend_rvalid1", {31'd0, rvalid1}, 32'd1);
        check("clr_pend_rdata1", rdata1, 32'h00000077);
        p_vld = 1'b0;
        n = 1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            nv += int'(rvalid0) + int'(rvalid1);
            if (ready0) break;
        end
        WE = 1'b0;
        RE = 1'b0;
        check("clr_ready_low", n, 16);
        check("clr_rvalid_in_sweep", nv, 0);
        check("clr_ready1", {31'd0, ready1}, 32'd1);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd0, 1'b1, IV, IV);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2, 1'b1, IV, IV);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);

        // Out-of-range on the DEPTH=10 instance (address 12)
        cyc(1'b1, 4'hF, 4'd12, 32'h12121212, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd12, 1'b1, 32'h12121212, 32'h12121212);
        check("oob_rvalid2", {31'd0, rvalid2}, 32'd1);
        check("oob_rdata2", rdata2, IV2);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);

`ifdef MEM_PARITY_EN
        // Parity injection on address 4, then clean rewrite
        PINJ = 1'b1;
        cyc(1'b1, 4'hF, 4'd4, 32'hCAFE0001, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        PINJ = 1'b0;
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd4, 1'b1, 32'hCAFE0001, 32'hCAFE0001);
        check("perr_inj0", {31'd0, perr0}, 32'd1);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        check("perr_inj1", {31'd0, perr1}, 32'd1);
        check("perr_qual0", {31'd0, perr0}, 32'd0);
        cyc(1'b1, 4'hF, 4'd4, 32'hCAFE0001, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd4, 1'b1, 32'hCAFE0001, 32'hCAFE0001);
        check("perr_clean0", {31'd0, perr0}, 32'd0);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        check("perr_clean1", {31'd0, perr1}, 32'd0);
`endif

        // Reset kills the in-flight dut1 read, then reset mid-sweep restarts it
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd1, 1'b1, IV, IV);
        RESET = 1'b1;
        p_vld = 1'b0;
        tick();
        check("kill_rvalid1", {31'd0, rvalid1}, 32'd0);
        check("kill_rdata1", rdata1, 32'h0);
        check("kill_rdata0", rdata0, 32'h0);
        check("kill_ready0", {31'd0, ready0}, 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_sweep_ready0", {31'd0, ready0}, 32'd0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        wait_ready(n0, n1, n2);
        check("resweep_len0", n0, 16);
        check("resweep_len1", n1, 16);
        check("resweep_len2", n2, 10);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b1, IV, IV);
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
